// File: rtl/interleaved_tap_buffer_if.sv
// Bus bundle for interleaved_tap_buffer.
// The master side drives the pixel write port and the window read request.
// The slave side, which is the buffer itself, returns the tap window and its valid strobe.
interface interleaved_tap_buffer_if #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 11,
    parameter int TAPS       = 4
) ();
    logic                       wr_en;
    logic [ADDR_WIDTH-1:0]      wr_addr;
    logic [DATA_WIDTH-1:0]      wr_data;
    logic                       rd_en;
    logic [ADDR_WIDTH:0]        rd_base;
    logic [ADDR_WIDTH-1:0]      line_last;
    logic                       edge_mode;
    logic                       rd_valid;
    logic [TAPS*DATA_WIDTH-1:0] rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_base, line_last, edge_mode,
        input  rd_valid, rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_base, line_last, edge_mode,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/interleaved_tap_buffer.sv
// Interleaved tap line buffer for the bicubic interpolation pipeline.
// Pixel a is stored in bank (a mod TAPS) at row (a >> log2(TAPS)). A window of
// TAPS consecutive addresses therefore touches each bank at most once per read.
// Edge handling is wrap (modulo buffer size) or clamp to [0, line_last].
// Read latency is 3 cycles: S1 (request), S2 (bank read), S3 (tap mux/output).
// A write is staged in W1 and committed to its bank one edge later. A read in
// the same cycle therefore sees the old contents.
module interleaved_tap_buffer #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 11,
    parameter int TAPS       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    interleaved_tap_buffer_if.slave tap_bus
);
    localparam int TAP_BITS = $clog2(TAPS);
    localparam int BANK_AW  = ADDR_WIDTH - TAP_BITS;
    localparam int ROWS     = 2 ** BANK_AW;
    localparam int SUM_W    = ADDR_WIDTH + 2;

    // ------------------------------------------------------------------
    // W1: registered write request
    // ------------------------------------------------------------------
    logic                  w1_en_q,   w1_en_d;
    logic [ADDR_WIDTH-1:0] w1_addr_q, w1_addr_d;
    logic [DATA_WIDTH-1:0] w1_data_q, w1_data_d;
    logic [BANK_AW-1:0]    w1_row_s;

    // Next-state for the write staging register; data/address only move on a write.
    always_comb begin
        w1_en_d   = tap_bus.wr_en;
        w1_addr_d = w1_addr_q;
        w1_data_d = w1_data_q;
        if (tap_bus.wr_en) begin
            w1_addr_d = tap_bus.wr_addr;
            w1_data_d = tap_bus.wr_data;
        end else begin
            w1_addr_d = w1_addr_q;
            w1_data_d = w1_data_q;
        end
    end

    // Write staging register; reset drops any pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w1_en_q   <= 1'b0;
            w1_addr_q <= '0;
            w1_data_q <= '0;
        end else begin
            w1_en_q   <= w1_en_d;
            w1_addr_q <= w1_addr_d;
            w1_data_q <= w1_data_d;
        end
    end

    assign w1_row_s = w1_addr_q[ADDR_WIDTH-1:TAP_BITS];

    // ------------------------------------------------------------------
    // S1: registered request, raw tap sums rd_base + k and edge controls
    // ------------------------------------------------------------------
    logic                    s1_vld_q,  s1_vld_d;
    logic                    s1_mode_q, s1_mode_d;
    logic [ADDR_WIDTH-1:0]   s1_last_q, s1_last_d;
    logic signed [SUM_W-1:0] s1_sum_q [TAPS];
    logic signed [SUM_W-1:0] s1_sum_d [TAPS];
    logic signed [SUM_W-1:0] base_ext_s;

    // Sign-extend the base and form one sum per tap. The extra bit leaves headroom, so no overflow occurs.
    always_comb begin
        base_ext_s = $signed({tap_bus.rd_base[ADDR_WIDTH], tap_bus.rd_base});
        s1_vld_d   = tap_bus.rd_en;
        s1_mode_d  = s1_mode_q;
        s1_last_d  = s1_last_q;
        for (int k = 0; k < TAPS; k++) begin
            s1_sum_d[k] = s1_sum_q[k];
        end
        if (tap_bus.rd_en) begin
            s1_mode_d = tap_bus.edge_mode;
            s1_last_d = tap_bus.line_last;
            for (int k = 0; k < TAPS; k++) begin
                s1_sum_d[k] = base_ext_s + $signed(SUM_W'(k));
            end
        end else begin
            s1_mode_d = s1_mode_q;
            s1_last_d = s1_last_q;
        end
    end

    // S1 pipeline register; the valid bit clears on reset so in-flight reads are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_mode_q <= 1'b0;
            s1_last_q <= '0;
            for (int k = 0; k < TAPS; k++) begin
                s1_sum_q[k] <= '0;
            end
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_mode_q <= s1_mode_d;
            s1_last_q <= s1_last_d;
            for (int k = 0; k < TAPS; k++) begin
                s1_sum_q[k] <= s1_sum_d[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: edge handling, per-bank row selection and bank read
    // ------------------------------------------------------------------
    logic signed [SUM_W-1:0] last_ext_s;
    logic [ADDR_WIDTH-1:0]   tap_addr_s [TAPS];
    logic [BANK_AW-1:0]      bank_row_s [TAPS];
    logic [DATA_WIDTH-1:0]   bank_rd_s  [TAPS];
    logic                    s2_vld_q,  s2_vld_d;
    logic [TAP_BITS-1:0]     s2_bank_q [TAPS];
    logic [TAP_BITS-1:0]     s2_bank_d [TAPS];

    assign last_ext_s = $signed({2'b00, s1_last_q});

    // Final tap address. Wrap keeps the low bits; clamp pins negatives to 0 and overshoot to line_last.
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            tap_addr_s[k] = s1_sum_q[k][ADDR_WIDTH-1:0];
            if (s1_mode_q && s1_sum_q[k][SUM_W-1]) begin
                tap_addr_s[k] = '0;
            end else if (s1_mode_q && (s1_sum_q[k] > last_ext_s)) begin
                tap_addr_s[k] = s1_last_q;
            end else begin
                tap_addr_s[k] = s1_sum_q[k][ADDR_WIDTH-1:0];
            end
        end
    end

    // Route each bank its row. Taps sharing a bank after clamping share the address, so any match is correct.
    always_comb begin
        for (int b = 0; b < TAPS; b++) begin
            bank_row_s[b] = '0;
            for (int k = 0; k < TAPS; k++) begin
                if (tap_addr_s[k][TAP_BITS-1:0] == TAP_BITS'(b)) begin
                    bank_row_s[b] = tap_addr_s[k][ADDR_WIDTH-1:TAP_BITS];
                end else begin
                    bank_row_s[b] = bank_row_s[b];
                end
            end
        end
    end

    // Bank index per tap, carried alongside the bank read into S3.
    always_comb begin
        s2_vld_d = s1_vld_q;
        for (int k = 0; k < TAPS; k++) begin
            s2_bank_d[k] = tap_addr_s[k][TAP_BITS-1:0];
        end
    end

    // S2 pipeline register for valid and per-tap bank index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                s2_bank_q[k] <= '0;
            end
        end else begin
            s2_vld_q <= s2_vld_d;
            for (int k = 0; k < TAPS; k++) begin
                s2_bank_q[k] <= s2_bank_d[k];
            end
        end
    end

    for (genvar b = 0; b < TAPS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem_q [ROWS];
        logic [DATA_WIDTH-1:0] rd_q;
        logic                  we_s;

        assign we_s         = w1_en_q && (w1_addr_q[TAP_BITS-1:0] == TAP_BITS'(b));
        assign bank_rd_s[b] = rd_q;

        // Bank RAM: one write port fed by W1 and one registered read port for S2. Read returns the pre-write contents.
        always_ff @(posedge clk) begin
            if (we_s) begin
                mem_q[w1_row_s] <= w1_data_q;
            end
            if (s1_vld_q) begin
                rd_q <= mem_q[bank_row_s[b]];
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: bank-to-tap mux and output register
    // ------------------------------------------------------------------
    logic                       rd_valid_q, rd_valid_d;
    logic [TAPS*DATA_WIDTH-1:0] rd_data_q,  rd_data_d;

    // Place each bank's word in its tap slot; the output holds while no window is in flight.
    always_comb begin
        rd_valid_d = s2_vld_q;
        rd_data_d  = rd_data_q;
        if (s2_vld_q) begin
            for (int k = 0; k < TAPS; k++) begin
                rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] = bank_rd_s[s2_bank_q[k]];
            end
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Output register; reset clears valid and data asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign tap_bus.rd_valid = rd_valid_q;
    assign tap_bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_interleaved_tap_buffer.sv
// Testbench for interleaved_tap_buffer. Three instances (TAPS = 2, 4, 8) get
// identical stimulus. Every output is compared against a pixel-array reference
// model: window = TAPS pixels at rd_base+k after wrap/clamp, visible three
// edges after the request edge. Writes become visible to requests issued one
// cycle later.
module tb_interleaved_tap_buffer;
    localparam int DW   = 24;
    localparam int AW   = 11;
    localparam int NPIX = 2048;
    localparam int PADW = 8 * DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          wr_en     = 1'b0;
    logic [AW-1:0] wr_addr   = '0;
    logic [DW-1:0] wr_data   = '0;
    logic          rd_en     = 1'b0;
    logic [AW:0]   rd_base   = '0;
    logic [AW-1:0] line_last = '0;
    logic          edge_mode = 1'b0;

    interleaved_tap_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAPS(2)) bus2 ();
    interleaved_tap_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAPS(4)) bus4 ();
    interleaved_tap_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAPS(8)) bus8 ();

    assign bus2.wr_en = wr_en;  assign bus2.wr_addr = wr_addr;  assign bus2.wr_data = wr_data;
    assign bus2.rd_en = rd_en;  assign bus2.rd_base = rd_base;  assign bus2.line_last = line_last;
    assign bus2.edge_mode = edge_mode;
    assign bus4.wr_en = wr_en;  assign bus4.wr_addr = wr_addr;  assign bus4.wr_data = wr_data;
    assign bus4.rd_en = rd_en;  assign bus4.rd_base = rd_base;  assign bus4.line_last = line_last;
    assign bus4.edge_mode = edge_mode;
    assign bus8.wr_en = wr_en;  assign bus8.wr_addr = wr_addr;  assign bus8.wr_data = wr_data;
    assign bus8.rd_en = rd_en;  assign bus8.rd_base = rd_base;  assign bus8.line_last = line_last;
    assign bus8.edge_mode = edge_mode;

    interleaved_tap_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAPS(2)) dut2 (.clk(clk), .rst_n(rst_n), .tap_bus(bus2));
    interleaved_tap_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAPS(4)) dut4 (.clk(clk), .rst_n(rst_n), .tap_bus(bus4));
    interleaved_tap_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAPS(8)) dut8 (.clk(clk), .rst_n(rst_n), .tap_bus(bus8));

    // Outputs zero-extended to a common width: index 0/1/2 = TAPS 2/4/8.
    logic [PADW-1:0] rd_pad [3];
    logic [2:0]      vld;
    assign rd_pad[0] = PADW'(bus2.rd_data);
    assign rd_pad[1] = PADW'(bus4.rd_data);
    assign rd_pad[2] = PADW'(bus8.rd_data);
    assign vld[0] = bus2.rd_valid;
    assign vld[1] = bus4.rd_valid;
    assign vld[2] = bus8.rd_valid;

    // Reference model state.
    logic [DW-1:0]   mem_model [NPIX];
    logic            exp_v     [3];
    logic [PADW-1:0] exp_w     [3][3];
    logic [PADW-1:0] exp_hold  [3];
    int checks   = 0;
    int failures = 0;

    function automatic logic [PADW-1:0] model_window(int base, bit clamp, int last, int t);
        logic [PADW-1:0] w;
        int s;
        w = '0;
        for (int k = 0; k < t; k++) begin
            s = base + k;
            if (clamp) begin
                if (s < 0) s = 0;
                if (s > last) s = last;
            end else begin
                s = s & (NPIX - 1);
            end
            w[k*DW +: DW] = mem_model[s];
        end
        return w;
    endfunction

    // One clock: record the current request against the model, apply the write, advance.
    task automatic tick();
        logic [PADW-1:0] w [3];
        for (int d = 0; d < 3; d++) begin
            w[d] = rd_en ? model_window(int'($signed(rd_base)), edge_mode, int'(line_last), 2 << d) : '0;
            exp_w[2][d] = exp_w[1][d];
            exp_w[1][d] = exp_w[0][d];
            exp_w[0][d] = w[d];
        end
        exp_v[2] = exp_v[1];
        exp_v[1] = exp_v[0];
        exp_v[0] = rd_en;
        if (wr_en) mem_model[wr_addr] = wr_data;
        if (exp_v[2]) begin
            for (int d = 0; d < 3; d++) exp_hold[d] = exp_w[2][d];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            exp_v[i] = 1'b0;
            exp_hold[i] = '0;
            for (int d = 0; d < 3; d++) exp_w[i][d] = '0;
        end
    endtask

    task automatic test_reset();
        model_clear();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (vld[d] !== 1'b0) begin failures++; $display("FAIL reset_valid dut%0d got %0b exp 0", d, vld[d]); end
            checks++;
            if (rd_pad[d] !== '0) begin failures++; $display("FAIL reset_data dut%0d got %h exp 0", d, rd_pad[d]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < NPIX; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(i);
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (vld[d] !== exp_v[2]) begin failures++; $display("FAIL fill_valid dut%0d got %0b exp %0b", d, vld[d], exp_v[2]); end
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b1; rd_base = 12'sd5; edge_mode = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            rd_en = 1'b0;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (vld[d] !== exp_v[2]) begin failures++; $display("FAIL t1_valid dut%0d cyc%0d got %0b exp %0b", d, j, vld[d], exp_v[2]); end
                checks++;
                if (rd_pad[d] !== exp_hold[d]) begin failures++; $display("FAIL t1_data dut%0d got %h exp %h", d, rd_pad[d], exp_hold[d]); end
            end
            if (j == 3) begin
                checks++;
                if (rd_pad[1][4*DW-1:0] !== {24'd8, 24'd7, 24'd6, 24'd5})
                    begin failures++; $display("FAIL t1_literal got %h exp 000008000007000006000005", rd_pad[1][4*DW-1:0]); end
            end
        end
    endtask

    // Two back-to-back requests; literal check on the TAPS=4 instance for each.
    task automatic test_edges(string name, int b0, bit m0, int b1, bit m1, logic [4*DW-1:0] lit0, logic [4*DW-1:0] lit1);
        line_last = 11'd639;
        rd_en = 1'b1; rd_base = (AW+1)'(b0); edge_mode = m0;
        tick();
        rd_base = (AW+1)'(b1); edge_mode = m1;
        for (int j = 2; j <= 6; j++) begin
            tick();
            rd_en = 1'b0;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (vld[d] !== exp_v[2]) begin failures++; $display("FAIL %s_valid dut%0d got %0b exp %0b", name, d, vld[d], exp_v[2]); end
                checks++;
                if (rd_pad[d] !== exp_hold[d]) begin failures++; $display("FAIL %s_data dut%0d got %h exp %h", name, d, rd_pad[d], exp_hold[d]); end
            end
            if (j == 3) begin
                checks++;
                if (rd_pad[1][4*DW-1:0] !== lit0) begin failures++; $display("FAIL %s_lit0 got %h exp %h", name, rd_pad[1][4*DW-1:0], lit0); end
            end
            if (j == 4) begin
                checks++;
                if (rd_pad[1][4*DW-1:0] !== lit1) begin failures++; $display("FAIL %s_lit1 got %h exp %h", name, rd_pad[1][4*DW-1:0], lit1); end
            end
        end
    endtask

    task automatic test_throughput();
        int base;
        int nvalid;
        base   = int'($urandom_range(2060)) - 10;
        nvalid = 0;
        edge_mode = 1'($urandom_range(1));
        line_last = AW'($urandom_range(NPIX - 1));
        for (int j = 0; j < 103; j++) begin
            rd_en   = (j < 100);
            rd_base = (AW+1)'(base + j);
            tick();
            if (vld[1] === 1'b1) nvalid++;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (vld[d] !== exp_v[2]) begin failures++; $display("FAIL t4_valid dut%0d cyc%0d got %0b exp %0b", d, j, vld[d], exp_v[2]); end
                checks++;
                if (rd_pad[d] !== exp_hold[d]) begin failures++; $display("FAIL t4_data dut%0d cyc%0d got %h exp %h", d, j, rd_pad[d], exp_hold[d]); end
            end
        end
        rd_en = 1'b0;
        checks++;
        if (nvalid !== 100) begin failures++; $display("FAIL t4_count got %0d exp 100", nvalid); end
    endtask

    task automatic test_collision();
        edge_mode = 1'b0;
        wr_en = 1'b1; wr_addr = 11'd8; wr_data = 24'hAAAAAA;
        tick();
        wr_en = 1'b0;
        tick();
        wr_en = 1'b1; wr_data = 24'h555555; rd_en = 1'b1; rd_base = 12'sd8;
        tick();
        wr_en = 1'b0;
        for (int j = 2; j <= 6; j++) begin
            tick();
            rd_en = 1'b0;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (vld[d] !== exp_v[2]) begin failures++; $display("FAIL t5_valid dut%0d got %0b exp %0b", d, vld[d], exp_v[2]); end
                checks++;
                if (rd_pad[d] !== exp_hold[d]) begin failures++; $display("FAIL t5_data dut%0d got %h exp %h", d, rd_pad[d], exp_hold[d]); end
            end
            if (j == 3) begin
                checks++;
                if (rd_pad[0][DW-1:0] !== 24'hAAAAAA) begin failures++; $display("FAIL t5_old got %h exp aaaaaa", rd_pad[0][DW-1:0]); end
            end
            if (j == 4) begin
                checks++;
                if (rd_pad[2][DW-1:0] !== 24'h555555) begin failures++; $display("FAIL t5_new got %h exp 555555", rd_pad[2][DW-1:0]); end
            end
        end
    endtask

    task automatic test_reset_midread();
        edge_mode = 1'b0;
        for (int j = 0; j < 4; j++) begin
            rd_en = 1'b1; rd_base = (AW+1)'(100 + j);
            tick();
        end
        rd_en = 1'b0;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (vld[d] !== 1'b1) begin failures++; $display("FAIL t6_pre_valid dut%0d got %0b exp 1", d, vld[d]); end
        end
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (vld[d] !== 1'b0) begin failures++; $display("FAIL t6_async_valid dut%0d got %0b exp 0", d, vld[d]); end
            checks++;
            if (rd_pad[d] !== '0) begin failures++; $display("FAIL t6_async_data dut%0d got %h exp 0", d, rd_pad[d]); end
        end
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 16; j++) begin
            rd_en = (j >= 5) && (j < 10);
            rd_base = (AW+1)'(int'($urandom_range(4095)) - 2048);
            edge_mode = 1'($urandom_range(1));
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (vld[d] !== exp_v[2]) begin failures++; $display("FAIL t6_valid dut%0d cyc%0d got %0b exp %0b", d, j, vld[d], exp_v[2]); end
                checks++;
                if (rd_pad[d] !== exp_hold[d]) begin failures++; $display("FAIL t6_data dut%0d cyc%0d got %h exp %h", d, j, rd_pad[d], exp_hold[d]); end
            end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 400; j++) begin
            wr_en     = ($urandom_range(99) < 50);
            wr_addr   = AW'($urandom_range(NPIX - 1));
            wr_data   = DW'($urandom);
            rd_en     = ($urandom_range(99) < 70);
            rd_base   = (AW+1)'(int'($urandom_range(4095)) - 2048);
            edge_mode = 1'($urandom_range(1));
            line_last = ($urandom_range(3) == 0) ? 11'd2047 : AW'($urandom_range(NPIX - 1));
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (vld[d] !== exp_v[2]) begin failures++; $display("FAIL rnd_valid dut%0d cyc%0d got %0b exp %0b", d, j, vld[d], exp_v[2]); end
                checks++;
                if (rd_pad[d] !== exp_hold[d]) begin failures++; $display("FAIL rnd_data dut%0d cyc%0d got %h exp %h", d, j, rd_pad[d], exp_hold[d]); end
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (rd_pad[d] !== exp_hold[d]) begin failures++; $display("FAIL rnd_drain dut%0d got %h exp %h", d, rd_pad[d], exp_hold[d]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_edges("t2", -1, 1'b1, -1, 1'b0,
                   {24'd2, 24'd1, 24'd0, 24'd0}, {24'd2, 24'd1, 24'd0, 24'd2047});
        test_edges("t3", 638, 1'b1, 2046, 1'b0,
                   {24'd639, 24'd639, 24'd639, 24'd638}, {24'd1, 24'd0, 24'd2047, 24'd2046});
        test_throughput();
        test_collision();
        test_reset_midread();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
